// File: rtl/src2_shift_pkg.sv
// Shared types and field positions for the ARM operand-2 generator.
package src2_shift_pkg;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_t;

    localparam int DATA_W     = 32;
    localparam int I_BIT      = 25;
    localparam int RS_SEL_BIT = 4;

endpackage

// File: rtl/src2_shift_rot.sv
// Combinational 32-bit rotate-right by a 5-bit amount.
module rot_right (
    input  logic [31:0] in_data,
    input  logic [4:0]  amt,
    output logic [31:0] out_data
);

    logic [63:0] doubled;

    // Shifting a doubled copy leaves the rotated word in the low half.
    assign doubled  = {in_data, in_data} >> amt;
    assign out_data = doubled[31:0];

endmodule

// File: rtl/src2_shift.sv
// ARM data-processing operand-2 generator with one registered output stage.
// Optional macro SRC2_RRX_EN: immediate ROR #0 performs RRX instead of a pass-through.
module src2_shift
    import src2_shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        carry_in,
    input  logic [31:0] Rs,
    input  logic [31:0] Rm,
    input  logic [25:0] imm,
    output logic [31:0] src2,
    output logic        carry_out,
    output logic        out_valid
);

    // Handshake: valid-only. in_valid=1 captures a result at the next rising edge;
    // out_valid is in_valid delayed one cycle. No ready: an operand is accepted every cycle.

    logic        i_bit;
    logic        reg_sel;
    shift_t      sh_type;
    logic [7:0]  rs_amt;
    logic [4:0]  amt5;
    logic [4:0]  amt_m1;
    logic [4:0]  amt_neg;
    logic [4:0]  imm_rot;
    logic [31:0] imm_rotated;
    logic [31:0] rm_rotated;
    logic [31:0] asr_val;
    logic [31:0] res;
    logic        res_c;

    assign i_bit   = imm[I_BIT];
    assign reg_sel = imm[RS_SEL_BIT];
    assign sh_type = shift_t'(imm[6:5]);
    assign rs_amt  = Rs[7:0];
    assign amt5    = reg_sel ? rs_amt[4:0] : imm[11:7];
    assign amt_m1  = amt5 - 5'd1;
    assign amt_neg = 5'd0 - amt5;
    assign imm_rot = {imm[11:8], 1'b0};
    assign asr_val = $signed(Rm) >>> amt5;

    rot_right u_rot_imm (
        .in_data  ({24'b0, imm[7:0]}),
        .amt      (imm_rot),
        .out_data (imm_rotated)
    );

    rot_right u_rot_rm (
        .in_data  (Rm),
        .amt      (amt5),
        .out_data (rm_rotated)
    );

    always_comb begin
        res   = Rm;
        res_c = carry_in;
        if (i_bit) begin
            res   = imm_rotated;
            res_c = (imm_rot == 5'd0) ? carry_in : imm_rotated[31];
        end else if (!reg_sel) begin
            // Immediate shift: an amount of 0 encodes special cases per type.
            unique case (sh_type)
                LSL: begin
                    if (amt5 != 5'd0) begin
                        res   = Rm << amt5;
                        res_c = Rm[amt_neg];
                    end
                end
                LSR: begin
                    res   = (amt5 == 5'd0) ? 32'd0 : (Rm >> amt5);
                    res_c = (amt5 == 5'd0) ? Rm[31] : Rm[amt_m1];
                end
                ASR: begin
                    res   = (amt5 == 5'd0) ? {32{Rm[31]}} : asr_val;
                    res_c = (amt5 == 5'd0) ? Rm[31] : Rm[amt_m1];
                end
                ROR: begin
                    if (amt5 != 5'd0) begin
                        res   = rm_rotated;
                        res_c = rm_rotated[31];
                    end else begin
`ifdef SRC2_RRX_EN
                        res   = {carry_in, Rm[31:1]};
                        res_c = Rm[0];
`else
                        res   = Rm;
                        res_c = carry_in;
`endif
                    end
                end
                default: ;
            endcase
        end else if (rs_amt != 8'd0) begin
            // Register shift by Rs[7:0]; amounts of 32 and above saturate per type.
            unique case (sh_type)
                LSL: begin
                    res = 32'd0;
                    if (rs_amt < 8'd32) begin
                        res   = Rm << amt5;
                        res_c = Rm[amt_neg];
                    end else begin
                        res_c = (rs_amt == 8'd32) ? Rm[0] : 1'b0;
                    end
                end
                LSR: begin
                    res = 32'd0;
                    if (rs_amt < 8'd32) begin
                        res   = Rm >> amt5;
                        res_c = Rm[amt_m1];
                    end else begin
                        res_c = (rs_amt == 8'd32) ? Rm[31] : 1'b0;
                    end
                end
                ASR: begin
                    res   = (rs_amt < 8'd32) ? asr_val : {32{Rm[31]}};
                    res_c = (rs_amt < 8'd32) ? Rm[amt_m1] : Rm[31];
                end
                ROR: begin
                    res   = rm_rotated;
                    res_c = (amt5 == 5'd0) ? Rm[31] : rm_rotated[31];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src2      <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                src2      <= res;
                carry_out <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_src2_shift.sv
// Scoreboard bench for src2_shift: directed vectors with hand-computed results.
module tb_src2_shift;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        carry_in = 1'b0;
    logic [31:0] Rs = '0;
    logic [31:0] Rm = '0;
    logic [25:0] imm = '0;
    logic [31:0] src2;
    logic        carry_out;
    logic        out_valid;

    logic [31:0] rr_in = '0;
    logic [5:0]  rr_amt6 = '0;
    logic [31:0] rr_out;

    logic [32:0] exp_q[$];
    logic [32:0] last_exp = '0;
    int          vectors = 0;
    int          miscompares = 0;

    src2_shift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .carry_in  (carry_in),
        .Rs        (Rs),
        .Rm        (Rm),
        .imm       (imm),
        .src2      (src2),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    rot_right u_rr (
        .in_data  (rr_in),
        .amt      (rr_amt6[4:0]),
        .out_data (rr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got c=%0b data=0x%08h, want c=%0b data=0x%08h",
                     name, act[32], act[31:0], exp[32], exp[31:0]);
        end
    endtask

    task automatic drive(input logic [31:0] rm_v, input logic [31:0] rs_v, input logic [25:0] imm_v,
                         input logic cin_v, input logic [31:0] exp_d, input logic exp_c);
        Rm       = rm_v;
        Rs       = rs_v;
        imm      = imm_v;
        carry_in = cin_v;
        in_valid = 1'b1;
        exp_q.push_back({exp_c, exp_d});
        last_exp = {exp_c, exp_d};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every presented result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {carry_out, src2}, 33'h1_dead_beef);
            end else begin
                check("scoreboard", {carry_out, src2}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rot_right directly, including the 5-bit wrap of 32 and 33.
        rr_in = 32'h0000F0F0; rr_amt6 = 6'd3;  #1 check("rot_amt3", {1'b0, rr_out}, {1'b0, 32'h00001E1E});
        rr_amt6 = 6'd5;  #1 check("rot_amt5", {1'b0, rr_out}, {1'b0, 32'h80000787});
        rr_in = 32'h0000A8C2; rr_amt6 = 6'd32; #1 check("rot_amt32", {1'b0, rr_out}, {1'b0, 32'h0000A8C2});
        rr_amt6 = 6'd33; #1 check("rot_amt33", {1'b0, rr_out}, {1'b0, 32'h00005461});

        #3;
        check("reset_state", {carry_out, src2}, 33'd0);
        check("reset_valid", {32'd0, out_valid}, 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rotated immediate.
        drive(32'h0, 32'h0, 26'h20002D6, 1'b1, 32'h6000000D, 1'b0);
        // Immediate shifts by 10.
        drive(32'h0000C58A, 32'h0, 26'h050A, 1'b0, 32'h03162800, 1'b0);
        drive(32'h0000C58A, 32'h0, 26'h052A, 1'b0, 32'h00000031, 1'b0);
        drive(32'h0000C58A, 32'h0, 26'h054A, 1'b0, 32'h00000031, 1'b0);
        drive(32'h0000C58A, 32'h0, 26'h056A, 1'b0, 32'h62800031, 1'b0);
        // Register shifts by 12.
        drive(32'hC000C58B, 32'h0000000C, 26'h051A, 1'b0, 32'h0C58B000, 1'b0);
        drive(32'hC000C58B, 32'h0000000C, 26'h053A, 1'b0, 32'h000C000C, 1'b0);
        drive(32'hC000C58B, 32'h0000000C, 26'h055A, 1'b0, 32'hFFFC000C, 1'b0);
        drive(32'hC000C58B, 32'h0000000C, 26'h057A, 1'b0, 32'h58BC000C, 1'b0);
        // imm[7] and Rs[31:8] ignored on register shifts.
        drive(32'hC000C58B, 32'hFFFFFF0C, 26'h00D0, 1'b0, 32'hFFFC000C, 1'b0);
        // Boundaries.
        drive(32'h80000000, 32'h0, 26'h0020, 1'b0, 32'h00000000, 1'b1);
        drive(32'h00000001, 32'd32, 26'h0010, 1'b0, 32'h00000000, 1'b1);
        drive(32'h00000001, 32'd33, 26'h0010, 1'b1, 32'h00000000, 1'b0);
        drive(32'h80000000, 32'd32, 26'h0030, 1'b0, 32'h00000000, 1'b1);
        drive(32'h80000000, 32'd40, 26'h0050, 1'b0, 32'hFFFFFFFF, 1'b1);
        drive(32'h80000001, 32'd32, 26'h0070, 1'b0, 32'h80000001, 1'b1);
        drive(32'h80000001, 32'd0,  26'h0070, 1'b0, 32'h80000001, 1'b0);
        drive(32'h80000001, 32'd0,  26'h0070, 1'b1, 32'h80000001, 1'b1);
        drive(32'h0000C58A, 32'h0, 26'h0000, 1'b1, 32'h0000C58A, 1'b1);
`ifdef SRC2_RRX_EN
        drive(32'h00000003, 32'h0, 26'h0060, 1'b1, 32'h80000001, 1'b1);
`else
        drive(32'h00000003, 32'h0, 26'h0060, 1'b1, 32'h00000003, 1'b1);
`endif

        // Outputs hold while in_valid is low, even as inputs change.
        Rm = 32'h12345678;
        imm = 26'h0000;
        idle(3);
        check("hold", {carry_out, src2}, last_exp);
        check("drained", {1'b0, 32'(exp_q.size())}, 33'd0);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        drive(32'h0000C58A, 32'h0, 26'h050A, 1'b1, 32'h03162800, 1'b0);
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {carry_out, src2}, 33'd0);
        check("async_reset_valid", {32'd0, out_valid}, 33'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(32'h0000C58A, 32'h0, 26'h052A, 1'b0, 32'h00000031, 1'b0);
        idle(2);
        check("final_drain", {1'b0, 32'(exp_q.size())}, 33'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
